vga_console_pixel_pipe: RTL and testbench
=========================================

// Module: vga_console_pixel_pipe
// PURPOSE
//  Parametrised, pipelined console pixel generator for the VGA console.
//  Turns a character cell stream into palette-indexed pixels:
//  - drives an external synchronous font ROM
//  - applies underline, strike-through, inverse and blink attributes
//  - selects foreground/background colour per cell
//  - holds a frame-counted blink phase internally
//  Sits between the console timing/char-buffer fetch and the DAC/palette stage.
// PARAMETERS
//  GLYPH_W      16  glyph width in pixels; glyph_x width = $clog2(GLYPH_W)
//  GLYPH_H      32  glyph height in lines; glyph_y width = $clog2(GLYPH_H)
//  COLOR_W      4   palette index width of fg/bg/out_color
//  BLINK_FRAMES 30  frames per blink half-period (>=1)
//  UL_ROW       28  first underline row; underline = rows UL_ROW, UL_ROW+1
//  ST_ROW       15  first strike row; strike = rows ST_ROW, ST_ROW+1
// PORTS
//  clk           in   1        pixel clock
//  rst_n         in   1        asynchronous, active-low reset
//  frame_tick    in   1        one-cycle pulse at start of each frame
//  in_valid      in   1        cell/pixel request valid (active video)
//  char_code     in   8        character code
//  char_attrs    in   4        [3] blink, [2] underline, [1] strike, [0] inverse
//  fg, bg        in   COLOR_W  foreground/background palette index
//  glyph_x       in   XW       pixel column in glyph
//  glyph_y       in   YW       pixel row in glyph
//  rom_codepoint out  7        font ROM address, combinational from char_code
//  rom_line_idx  out  YW       font ROM line, = glyph_y
//  rom_line      in   GLYPH_W  ROM data, valid 1 clk after address
//  out_valid     out  1        pixel valid
//  out_pixel     out  1        final foreground/background decision
//  out_color     out  COLOR_W  palette index; 0 when out_valid=0
// BEHAVIOUR
//  ROM addressing:
//  - rom_codepoint = char_code[6:0], or 0 if char_code[7]=1
//  Pipeline, fixed latency 2:
//  - S1 (edge N+1) registers valid, x, y, attrs, fg, bg; rom_line valid in S1
//  - S2 (edge N+2) registers outputs computed from S1 and rom_line
//  - No stall; in_valid=0 inputs flow through as bubbles
//  Pixel computation:
//  - f = rom_line[x_s1] | (ul & y in {UL_ROW, UL_ROW+1}) | (st & y in {ST_ROW, ST_ROW+1})
//  - p = f ^ inv
//  - if blink & ~blink_phase: p = inv (cell shows its bg-side only)
//  - out_pixel = valid_s1 & p
//  - out_color = valid_s1 ? (p ? fg : bg) : 0
//  Blink:
//  - frame counter 0..BLINK_FRAMES-1, advances on frame_tick
//  - on wrap, toggle blink_phase
//  - phase changes take effect for S1 data on the cycle after the tick
//  - frame_tick coincident with in_valid is legal
//  Reset (async assert, sync release):
//  - out_valid=0, out_pixel=0, out_color=0
//  - pipeline valids=0, counter=0, blink_phase=1 (visible)
//  - mid-line reset drops in-flight pixels; no partial output after release
//  Row compares are full width; rows >= GLYPH_H never match.
// CONFIGURATION
//  VGA_CONSOLE_CURSOR_EN defined:
//  - adds input in_cursor (1b, pipelined with data) and parameter CURSOR_ROW
//    (default 28)
//  - when in_cursor=1, blink_phase=1 and y >= CURSOR_ROW: final p is inverted
//  - underline-style blinking cursor; overrides char blink masking
//  Undefined:
//  - no in_cursor port, no cursor logic; behaviour otherwise identical
// TESTING
//  1. Reset, 'A' (0x41), attrs=0, fg=15, bg=1, y=5, sweep x
//     -> rom_codepoint=0x41; out_color follows rom_line bits 2 clks later, 15/1.
//  2. char_code=0xC1 -> rom_codepoint=0x00.
//     underline=1, y=28 and y=29 -> out_pixel=1 all x; y=27 -> ROM data only.
//  3. inverse=1, rom_line=16'h00FF, y=3 -> x=0..7 give bg, x=8..15 give fg.
//     Same with strike=1, y=15 -> all bg.
//  4. BLINK_FRAMES=2, blink=1, pulse frame_tick x4
//     -> visible, hidden after tick 2, visible after tick 4.
//     Hidden cell outputs bg; non-blink cell unaffected.
//  5. in_valid toggled each cycle
//     -> out_valid is the same pattern delayed 2 clks, out_color=0 on gaps.
//     rst_n low mid-stream -> outputs 0 immediately; phase=1 after release.
//  6. (VGA_CONSOLE_CURSOR_EN) in_cursor=1, CURSOR_ROW=28, y=30, blank glyph
//     -> fg in visible phase, bg in hidden phase.

Source files
------------

// File: rtl/vga_console_pixel_pipe.sv
//------------------------------------------------------------------------------
// Module   : vga_console_pixel_pipe
// Brief    : Two-stage console pixel generator: font ROM lookup, text
//            attributes, blink phase and fg/bg palette selection.
//            Optional underline cursor enabled by VGA_CONSOLE_CURSOR_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vga_console_pixel_pipe #(
  parameter int GLYPH_W      = 16,
  parameter int GLYPH_H      = 32,
  parameter int COLOR_W      = 4,
  parameter int BLINK_FRAMES = 30,
  parameter int UL_ROW       = 28,
`ifdef VGA_CONSOLE_CURSOR_EN
  parameter int CURSOR_ROW   = 28,
`endif
  parameter int ST_ROW       = 15
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_tick,
  input  logic                        in_valid,
  input  logic [7:0]                  char_code,
  input  logic [3:0]                  char_attrs,
  input  logic [COLOR_W-1:0]          fg,
  input  logic [COLOR_W-1:0]          bg,
  input  logic [$clog2(GLYPH_W)-1:0]  glyph_x,
  input  logic [$clog2(GLYPH_H)-1:0]  glyph_y,
`ifdef VGA_CONSOLE_CURSOR_EN
  input  logic                        in_cursor,
`endif
  output logic [6:0]                  rom_codepoint,
  output logic [$clog2(GLYPH_H)-1:0]  rom_line_idx,
  input  logic [GLYPH_W-1:0]          rom_line,
  output logic                        out_valid,
  output logic                        out_pixel,
  output logic [COLOR_W-1:0]          out_color
);

  localparam int c_XW = $clog2(GLYPH_W);
  localparam int c_YW = $clog2(GLYPH_H);
  localparam int c_CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                r_valid_s1;
  logic [c_XW-1:0]     r_x_s1;
  logic [c_YW-1:0]     r_y_s1;
  logic [3:0]          r_attrs_s1;
  logic [COLOR_W-1:0]  r_fg_s1;
  logic [COLOR_W-1:0]  r_bg_s1;
`ifdef VGA_CONSOLE_CURSOR_EN
  logic                r_cursor_s1;
`endif
  logic [c_CW-1:0]     r_frame_cnt;
  logic                r_blink_phase;

  logic [31:0]         w_y32;
  logic                w_f;
  logic                w_p;

  // Codes with bit 7 set have no glyph and fall back to codepoint 0.
  assign rom_codepoint = char_code[7] ? 7'd0 : char_code[6:0];
  assign rom_line_idx  = glyph_y;

  function automatic logic row_pair(input logic [31:0] y, input int row);
    return (y < 32'(GLYPH_H)) && ((y == 32'(row)) || (y == 32'(row + 1)));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_s1  <= 1'b0;
      r_x_s1      <= '0;
      r_y_s1      <= '0;
      r_attrs_s1  <= '0;
      r_fg_s1     <= '0;
      r_bg_s1     <= '0;
`ifdef VGA_CONSOLE_CURSOR_EN
      r_cursor_s1 <= 1'b0;
`endif
    end else begin
      r_valid_s1  <= in_valid;
      r_x_s1      <= glyph_x;
      r_y_s1      <= glyph_y;
      r_attrs_s1  <= char_attrs;
      r_fg_s1     <= fg;
      r_bg_s1     <= bg;
`ifdef VGA_CONSOLE_CURSOR_EN
      r_cursor_s1 <= in_cursor;
`endif
    end
  end

  // Phase is 1 (visible) out of reset and flips every BLINK_FRAMES ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (frame_tick) begin
      if (r_frame_cnt == c_CW'(BLINK_FRAMES - 1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_y32 = 32'(r_y_s1);
    w_f   = rom_line[r_x_s1]
          | (r_attrs_s1[2] & row_pair(w_y32, UL_ROW))
          | (r_attrs_s1[1] & row_pair(w_y32, ST_ROW));
    w_p   = w_f ^ r_attrs_s1[0];
    if (r_attrs_s1[3] && !r_blink_phase) begin
      w_p = r_attrs_s1[0];
    end
`ifdef VGA_CONSOLE_CURSOR_EN
    if (r_cursor_s1 && r_blink_phase &&
        (w_y32 >= 32'(CURSOR_ROW)) && (w_y32 < 32'(GLYPH_H))) begin
      w_p = ~w_p;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pixel <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= r_valid_s1;
      out_pixel <= r_valid_s1 & w_p;
      out_color <= r_valid_s1 ? (w_p ? r_fg_s1 : r_bg_s1) : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_console_pixel_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_vga_console_pixel_pipe
// Brief    : Randomized self-checking bench with a frame-count blink model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vga_console_pixel_pipe;

  localparam int c_BF = 2;
`ifdef VGA_CONSOLE_CURSOR_EN
  localparam bit c_CUR_EN = 1'b1;
`else
  localparam bit c_CUR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        in_valid;
  logic [7:0]  char_code;
  logic [3:0]  char_attrs;
  logic [3:0]  fg, bg;
  logic [3:0]  glyph_x;
  logic [4:0]  glyph_y;
  logic        in_cursor;
  logic [6:0]  rom_codepoint;
  logic [4:0]  rom_line_idx;
  logic [15:0] rom_line;
  logic        out_valid, out_pixel;
  logic [3:0]  out_color;

  logic [15:0] font [0:127][0:31];
  logic [5:0]  e0, e1;
  int          ticks = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  vga_console_pixel_pipe #(
    .BLINK_FRAMES(c_BF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .in_valid     (in_valid),
    .char_code    (char_code),
    .char_attrs   (char_attrs),
    .fg           (fg),
    .bg           (bg),
    .glyph_x      (glyph_x),
    .glyph_y      (glyph_y),
`ifdef VGA_CONSOLE_CURSOR_EN
    .in_cursor    (in_cursor),
`endif
    .rom_codepoint(rom_codepoint),
    .rom_line_idx (rom_line_idx),
    .rom_line     (rom_line),
    .out_valid    (out_valid),
    .out_pixel    (out_pixel),
    .out_color    (out_color)
  );

  // External synchronous font ROM.
  always @(posedge clk) rom_line <= font[rom_codepoint][rom_line_idx];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected {valid, pixel, color} for one input cell, given ticks seen so far.
  function automatic logic [5:0] model(input logic v, input logic [7:0] code,
      input logic [3:0] at, input logic [3:0] f, input logic [3:0] b,
      input logic [3:0] x, input logic [4:0] y, input logic cur);
    logic [6:0]  cp;
    logic [15:0] line;
    logic        vis, pix;
    cp   = code[7] ? 7'd0 : code[6:0];
    line = font[cp][y];
    vis  = ((ticks / c_BF) % 2) == 0;
    pix  = line[x];
    if (at[2] && (y == 5'd28 || y == 5'd29)) pix = 1'b1;
    if (at[1] && (y == 5'd15 || y == 5'd16)) pix = 1'b1;
    pix = pix ^ at[0];
    if (at[3] && !vis) pix = at[0];
    if (c_CUR_EN && cur && vis && y >= 5'd28) pix = ~pix;
    if (!v) return 6'd0;
    return {1'b1, pix, pix ? f : b};
  endfunction

  task automatic step(input logic v, input logic [7:0] code, input logic [3:0] at,
      input logic [3:0] f, input logic [3:0] b, input logic [3:0] x,
      input logic [4:0] y, input logic tick, input logic cur);
    logic [6:0] exp_cp;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(e1[5]));
    check("out_pixel", 32'(out_pixel), 32'(e1[4]));
    check("out_color", 32'(out_color), 32'(e1[3:0]));
    e1 = e0;
    in_valid   = v;
    char_code  = code;
    char_attrs = at;
    fg         = f;
    bg         = b;
    glyph_x    = x;
    glyph_y    = y;
    frame_tick = tick;
    in_cursor  = cur;
    if (tick) ticks++;
    e0 = model(v, code, at, f, b, x, y, cur);
    exp_cp = code[7] ? 7'd0 : code[6:0];
    #1;
    check("rom_codepoint", 32'(rom_codepoint), 32'(exp_cp));
    check("rom_line_idx", 32'(rom_line_idx), 32'(y));
  endtask

  task automatic rand_step(input logic v);
    step(v, 8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
         4'($urandom), 5'($urandom), ($urandom_range(0, 11) == 0),
         1'($urandom));
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pixel", 32'(out_pixel), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    in_valid   = 1'b0;
    frame_tick = 1'b0;
    e0 = '0;
    e1 = '0;
    ticks = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int c = 0; c < 128; c++)
      for (int l = 0; l < 32; l++)
        font[c][l] = 16'($urandom);
    font[7'h20][3] = 16'h00FF;
    for (int l = 0; l < 32; l++) font[7'h7F][l] = 16'h0000;

    rst_n = 1'b0; frame_tick = 1'b0; in_valid = 1'b0; char_code = '0;
    char_attrs = '0; fg = '0; bg = '0; glyph_x = '0; glyph_y = '0;
    in_cursor = 1'b0; e0 = '0; e1 = '0;
    repeat (3) @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_pixel", 32'(out_pixel), 32'd0);
    check("reset_out_color", 32'(out_color), 32'd0);
    rst_n = 1'b1;

    // 'A' with plain attributes across one glyph row
    for (int x = 0; x < 16; x++) step(1'b1, 8'h41, 4'h0, 4'd15, 4'd1, 4'(x), 5'd5, 1'b0, 1'b0);
    // High codes map to glyph 0; underline rows vs. the row just above
    for (int r = 0; r < 3; r++)
      for (int x = 0; x < 16; x++)
        step(1'b1, 8'hC1, 4'b0100, 4'd15, 4'd1, 4'(x), 5'(29 - ((r + 2) % 3)), 1'b0, 1'b0);
    // Inverse over a half-lit row, then strike + inverse fully background
    for (int x = 0; x < 16; x++) step(1'b1, 8'h20, 4'b0001, 4'd12, 4'd3, 4'(x), 5'd3, 1'b0, 1'b0);
    for (int x = 0; x < 16; x++) step(1'b1, 8'h20, 4'b0011, 4'd12, 4'd3, 4'(x), 5'd15, 1'b0, 1'b0);
    // Blink across four frame ticks with blink and non-blink cells interleaved
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 6; i++)
        step(1'b1, 8'h41, (i % 2 == 0) ? 4'b1000 : 4'b0000, 4'd15, 4'd1,
             4'($urandom), 5'd5, (i == 5), 1'b0);
    // Alternating valid bubbles
    for (int i = 0; i < 40; i++) rand_step(1'(i % 2));
    // Random traffic, mid-stream reset, more random traffic
    for (int i = 0; i < 1200; i++) rand_step(1'($urandom_range(0, 3) != 0));
    mid_reset();
    for (int i = 0; i < 400; i++) rand_step(1'($urandom_range(0, 3) != 0));
`ifdef VGA_CONSOLE_CURSOR_EN
    // Underline cursor on a blank glyph across both blink phases
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 4; i++)
        step(1'b1, 8'h7F, 4'h0, 4'd15, 4'd1, 4'(i), 5'd30, (i == 3), 1'b1);
`endif
    step(1'b0, 8'h00, 4'h0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'h0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'h0, 4'd0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
